// File: rtl/rv32i_operand_fetch.sv
// RV32I operand fetch: reads rs1/rs2 through the single synchronous register-file
// read port, forces x0 to zero and forwards in-flight writebacks.
module rv32i_operand_fetch #(
  parameter int DATA_WIDTH     = 32,
  parameter int GPR_ADDR_WIDTH = 9,
  parameter int REG_ENABLE     = 0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [4:0]                req_rs1,
  input  logic [4:0]                req_rs2,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_rs1_data,
  output logic [DATA_WIDTH-1:0]     rsp_rs2_data,
  input  logic                      wb_valid,
  input  logic [4:0]                wb_rd,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_rdaddress,
  output logic                      gpr_rden,
  input  logic [DATA_WIDTH-1:0]     gpr_q,
  output logic [GPR_ADDR_WIDTH-1:0] gpr_wraddress,
  output logic                      gpr_wren,
  output logic [DATA_WIDTH-1:0]     gpr_data
);

  localparam int         L    = 1 + REG_ENABLE;
  localparam logic [2:0] CAP1 = 3'(1 + L);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE1, S_ISSUE2, S_WAIT, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [4:0]            rs1_q, rs1_d, rs2_q, rs2_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [2:0]            cyc_q, cyc_d;
  logic                  fwd1_q, fwd1_d, fwd2_q, fwd2_d;
  logic [DATA_WIDTH-1:0] fv1_q, fv1_d, fv2_q, fv2_d;
  logic [DATA_WIDTH-1:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;

  logic [4:0] idx1, idx2;
  logic       hit1, hit2;

  assign gpr_wren      = wb_valid && (wb_rd != 5'd0);
  assign gpr_wraddress = {{(GPR_ADDR_WIDTH-5){1'b0}}, wb_rd};
  assign gpr_data      = wb_data;

  assign rsp_rs1_data = rs1_data_q;
  assign rsp_rs2_data = rs2_data_q;

  // In IDLE the accept-cycle writeback is compared against the incoming indices.
  assign idx1 = (state_q == S_IDLE) ? req_rs1 : rs1_q;
  assign idx2 = (state_q == S_IDLE) ? req_rs2 : rs2_q;
  assign hit1 = wb_valid && (wb_rd != 5'd0) && (wb_rd == idx1);
  assign hit2 = wb_valid && (wb_rd != 5'd0) && (wb_rd == idx2);

  always_comb begin
    state_d       = state_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    cnt_d         = cnt_q;
    cyc_d         = cyc_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    gpr_rden      = 1'b0;
    gpr_rdaddress = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          cyc_d   = 3'd1;
          state_d = S_ISSUE1;
        end
      end
      S_ISSUE1: begin
        gpr_rden      = 1'b1;
        gpr_rdaddress = {{(GPR_ADDR_WIDTH-5){1'b0}}, rs1_q};
        cyc_d         = cyc_q + 3'd1;
        state_d       = S_ISSUE2;
      end
      S_ISSUE2: begin
        gpr_rden      = 1'b1;
        gpr_rdaddress = {{(GPR_ADDR_WIDTH-5){1'b0}}, rs2_q};
        cnt_d         = 2'(L - 1);
        cyc_d         = cyc_q + 3'd1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        cyc_d = cyc_q + 3'd1;
        if (cnt_q == 2'd0) state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fwd1_d = fwd1_q;
    fv1_d  = fv1_q;
    fwd2_d = fwd2_q;
    fv2_d  = fv2_q;
    if (state_q == S_IDLE) begin
      if (req_valid) begin
        fwd1_d = hit1;
        fv1_d  = wb_data;
        fwd2_d = hit2;
        fv2_d  = wb_data;
      end
    end else begin
      if (hit1) begin
        fwd1_d = 1'b1;
        fv1_d  = wb_data;
      end
      if (hit2) begin
        fwd2_d = 1'b1;
        fv2_d  = wb_data;
      end
    end
  end

  // A writeback landing in the capture cycle beats both the stored forward and the RAM.
  always_comb begin
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    if (state_q != S_IDLE && state_q != S_RESP && cyc_q == CAP1) begin
      if (rs1_q == 5'd0)  rs1_data_d = '0;
      else if (hit1)      rs1_data_d = wb_data;
      else if (fwd1_q)    rs1_data_d = fv1_q;
      else                rs1_data_d = gpr_q;
    end
    if (state_q == S_WAIT && cnt_q == 2'd0) begin
      if (rs2_q == 5'd0)  rs2_data_d = '0;
      else if (hit2)      rs2_data_d = wb_data;
      else if (fwd2_q)    rs2_data_d = fv2_q;
      else                rs2_data_d = gpr_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      rs1_q      <= '0;
      rs2_q      <= '0;
      cnt_q      <= '0;
      cyc_q      <= '0;
      fwd1_q     <= 1'b0;
      fwd2_q     <= 1'b0;
      fv1_q      <= '0;
      fv2_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      cnt_q      <= cnt_d;
      cyc_q      <= cyc_d;
      fwd1_q     <= fwd1_d;
      fwd2_q     <= fwd2_d;
      fv1_q      <= fv1_d;
      fv2_q      <= fv2_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
    end
  end

endmodule

// File: tb/tb_rv32i_operand_fetch.sv
// Bench for rv32i_operand_fetch: one instance per register-file latency, shared stimulus,
// architectural register model plus literal response checks.
module tb_rv32i_operand_fetch;

  logic        clock = 1'b0;
  logic        reset_n, req_valid, rsp_ready, wb_valid;
  logic [4:0]  req_rs1, req_rs2, wb_rd;
  logic [31:0] wb_data;

  logic [1:0]  req_ready_w, rsp_valid_w, rden_w, wren_w;
  logic [31:0] rs1d_w [2];
  logic [31:0] rs2d_w [2];
  logic [31:0] gq_w   [2];
  logic [31:0] gdat_w [2];
  logic [8:0]  rda_w  [2];
  logic [8:0]  wra_w  [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clock = ~clock;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [31:0] mem [32];
    logic [31:0] q1, q2;

    rv32i_operand_fetch #(.DATA_WIDTH(32), .GPR_ADDR_WIDTH(9), .REG_ENABLE(gi)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready_w[gi]),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .rsp_valid(rsp_valid_w[gi]), .rsp_ready(rsp_ready),
      .rsp_rs1_data(rs1d_w[gi]), .rsp_rs2_data(rs2d_w[gi]),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .gpr_rdaddress(rda_w[gi]), .gpr_rden(rden_w[gi]), .gpr_q(gq_w[gi]),
      .gpr_wraddress(wra_w[gi]), .gpr_wren(wren_w[gi]), .gpr_data(gdat_w[gi])
    );

    // Read-first synchronous RAM with one or two output stages
    always @(posedge clock) begin
      if (rden_w[gi]) q1 <= mem[rda_w[gi][4:0]];
      q2 <= q1;
      if (wren_w[gi]) mem[wra_w[gi][4:0]] <= gdat_w[gi];
    end
    if (gi == 0) begin : g_l1
      assign gq_w[gi] = q1;
    end else begin : g_l2
      assign gq_w[gi] = q2;
    end
  end

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut%0d at %0t: got %h, expected %h", nm, d, $time, act, exp);
    end
  endtask

  // Architectural model: k = cycles since accept (-1 idle), operands sampled at capture cycles
  logic [31:0] arch [32] = '{default: 32'h0};
  int          k    [2]  = '{-1, -1};
  logic [4:0]  m_rs1 [2];
  logic [4:0]  m_rs2 [2];
  logic [31:0] e1 [2];
  logic [31:0] e2 [2];

  always @(posedge clock) begin
    if (wb_valid && wb_rd != 5'd0) arch[wb_rd] = wb_data;
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        k[d] = -1;
      end else begin
        if (k[d] == 2 + d) e1[d] = arch[m_rs1[d]];
        if (k[d] == 3 + d) e2[d] = arch[m_rs2[d]];
        if (k[d] == -1) begin
          if (req_valid) begin
            m_rs1[d] = req_rs1;
            m_rs2[d] = req_rs2;
            k[d]     = 1;
          end
        end else if (k[d] < 4 + d) begin
          k[d] = k[d] + 1;
        end else if (rsp_ready) begin
          k[d] = -1;
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      logic idle, issue, vld;
      logic [4:0] ea;
      idle  = !reset_n || k[d] == -1;
      issue = reset_n && (k[d] == 1 || k[d] == 2);
      vld   = reset_n && k[d] == 4 + d;
      ea    = !issue ? 5'd0 : (k[d] == 1) ? m_rs1[d] : m_rs2[d];
      chk("req_ready", d, {31'b0, req_ready_w[d]}, {31'b0, idle});
      chk("gpr_rden", d, {31'b0, rden_w[d]}, {31'b0, issue});
      chk("gpr_rdaddress", d, {23'b0, rda_w[d]}, {27'b0, ea});
      chk("rsp_valid", d, {31'b0, rsp_valid_w[d]}, {31'b0, vld});
      if (vld) begin
        chk("rsp_rs1_data", d, rs1d_w[d], e1[d]);
        chk("rsp_rs2_data", d, rs2d_w[d], e2[d]);
      end
      chk("gpr_wren", d, {31'b0, wren_w[d]}, {31'b0, wb_valid && wb_rd != 5'd0});
      chk("gpr_wraddress", d, {23'b0, wra_w[d]}, {27'b0, wb_rd});
      chk("gpr_data", d, gdat_w[d], wb_data);
    end
  end

  int          lat  [2];
  logic [31:0] got1 [2];
  logic [31:0] got2 [2];

  task automatic drive_wb(input int n, input int ac, input logic [4:0] ar, input logic [31:0] ad,
                          input int bc, input logic [4:0] br, input logic [31:0] bd);
    wb_valid = (n == ac) || (n == bc);
    wb_rd    = (n == ac) ? ar : (n == bc) ? br : 5'd0;
    wb_data  = (n == ac) ? ad : (n == bc) ? bd : 32'h0;
  endtask

  task automatic wb_write(input logic [4:0] rd, input logic [31:0] dat);
    drive_wb(0, 0, rd, dat, -1, 5'd0, 32'h0);
    @(posedge clock); #1;
    drive_wb(1, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0);
  endtask

  // Entered just after a rising edge; that cycle is the accept cycle 0.
  task automatic do_req(input logic [4:0] r1, input logic [4:0] r2,
                        input int ac, input logic [4:0] ar, input logic [31:0] ad,
                        input int bc, input logic [4:0] br, input logic [31:0] bd,
                        input int hold, input int rst_cyc);
    lat[0] = -1;
    lat[1] = -1;
    req_valid = 1'b1;
    req_rs1   = r1;
    req_rs2   = r2;
    rsp_ready = (hold == 0);
    drive_wb(0, ac, ar, ad, bc, br, bd);
    for (int c = 0; c < 24; c++) begin
      @(negedge clock);
      if (rst_cyc < 0 && c == 1) chk("issue1_addr_lit", 0, {23'b0, rda_w[0]}, {27'b0, r1});
      if (rst_cyc < 0 && c == 2) chk("issue2_addr_lit", 0, {23'b0, rda_w[0]}, {27'b0, r2});
      for (int d = 0; d < 2; d++) begin
        if (lat[d] < 0 && rsp_valid_w[d]) begin
          lat[d]  = c;
          got1[d] = rs1d_w[d];
          got2[d] = rs2d_w[d];
          $display("dut%0d req rs1=x%0d rs2=x%0d -> rsp cycle %0d rs1=%h rs2=%h",
                   d, r1, r2, c, got1[d], got2[d]);
        end
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      drive_wb(c + 1, ac, ar, ad, bc, br, bd);
      rsp_ready = (c + 1 >= hold);
      if (rst_cyc >= 0) begin
        reset_n = !(c + 1 >= rst_cyc && c + 1 < rst_cyc + 2);
        if (c + 1 == rst_cyc) begin
          #1;
          for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready_lit", d, {31'b0, req_ready_w[d]}, 32'd1);
            chk("rst_rsp_valid_lit", d, {31'b0, rsp_valid_w[d]}, 32'd0);
          end
        end
      end
    end
    if (rst_cyc >= 0) $display("req rs1=x%0d rs2=x%0d abandoned by reset", r1, r2);
  endtask

  task automatic expect_rsp(input string nm, input int d, input int l,
                            input logic [31:0] x1, input logic [31:0] x2);
    chk({nm, "_latency"}, d, lat[d], l);
    if (l >= 0) begin
      chk({nm, "_rs1"}, d, got1[d], x1);
      chk({nm, "_rs2"}, d, got2[d], x2);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_rs1   = 5'd0;
    req_rs2   = 5'd0;
    rsp_ready = 1'b1;
    wb_valid  = 1'b1;
    wb_rd     = 5'd3;
    wb_data   = 32'h0000_00A5;
    @(negedge clock); @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", d, {31'b0, req_ready_w[d]}, 32'd1);
      chk("reset_rsp_valid", d, {31'b0, rsp_valid_w[d]}, 32'd0);
      chk("reset_rs1_data", d, rs1d_w[d], 32'h0);
      chk("reset_rs2_data", d, rs2d_w[d], 32'h0);
      chk("reset_rden", d, {31'b0, rden_w[d]}, 32'd0);
      chk("reset_wren_follows_wb", d, {31'b0, wren_w[d]}, 32'd1);
    end
    @(posedge clock); #1;
    wb_valid = 1'b0;
    reset_n  = 1'b1;

    wb_write(5'd5, 32'h1234_5678);
    wb_write(5'd6, 32'hDEAD_BEEF);
    @(posedge clock); #1;
    @(posedge clock); #1;
    wb_write(5'd7, 32'h0000_0011);

    do_req(5'd5, 5'd6, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0, 0, -1);
    expect_rsp("basic", 0, 4, 32'h1234_5678, 32'hDEAD_BEEF);
    expect_rsp("basic", 1, 5, 32'h1234_5678, 32'hDEAD_BEEF);

    do_req(5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, -1, 5'd0, 32'h0, 0, -1);
    expect_rsp("x0", 0, 4, 32'h0, 32'h0);
    expect_rsp("x0", 1, 5, 32'h0, 32'h0);

    do_req(5'd7, 5'd7, 1, 5'd7, 32'h22, 3, 5'd7, 32'h33, 0, -1);
    expect_rsp("fwd", 0, 4, 32'h22, 32'h33);
    expect_rsp("fwd", 1, 5, 32'h33, 32'h33);

    do_req(5'd5, 5'd6, 8, 5'd5, 32'h99, -1, 5'd0, 32'h0, 16, -1);
    expect_rsp("stall", 0, 4, 32'h1234_5678, 32'hDEAD_BEEF);
    expect_rsp("stall", 1, 5, 32'h1234_5678, 32'hDEAD_BEEF);

    do_req(5'd5, 5'd6, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0, 0, 3);
    expect_rsp("abandon", 0, -1, 32'h0, 32'h0);
    expect_rsp("abandon", 1, -1, 32'h0, 32'h0);

    do_req(5'd5, 5'd6, -1, 5'd0, 32'h0, -1, 5'd0, 32'h0, 0, -1);
    expect_rsp("post_reset", 0, 4, 32'h99, 32'hDEAD_BEEF);
    expect_rsp("post_reset", 1, 5, 32'h99, 32'hDEAD_BEEF);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
